// File: rtl/bsg_manycore_link_profiler.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_link_profiler
// Brief    : Per-tile link traffic profiler. Counts outgoing fwd/rev transfers
//            and stalls per direction, snapshots them into a shadow bank, and
//            serves shadow values over a single-outstanding read handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_manycore_link_profiler #(
  parameter int addr_width_p    = 8,
  parameter int data_width_p    = 16,
  parameter int x_cord_width_p  = 3,
  parameter int y_cord_width_p  = 2,
  parameter int load_id_width_p = 4,
  parameter int counter_width_p = 32,
  parameter int dirs_lp         = 4,
  localparam int fwd_pkt_width_lp = 2 + addr_width_p + data_width_p + load_id_width_p
                                    + 2*(x_cord_width_p + y_cord_width_p),
  localparam int rev_pkt_width_lp = 2 + data_width_p + load_id_width_p
                                    + x_cord_width_p + y_cord_width_p,
  localparam int link_sif_width_lp = (fwd_pkt_width_lp + 2) + (rev_pkt_width_lp + 2)
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic [dirs_lp-1:0][link_sif_width_lp-1:0]    links_sif_i,
  input  logic [dirs_lp-1:0][link_sif_width_lp-1:0]    links_sif_o,
  input  logic                                         freeze_i,
  input  logic                                         snapshot_i,
  input  logic                                         rd_v_i,
  input  logic [4:0]                                   rd_addr_i,
  output logic                                         rd_ready_o,
  output logic                                         rd_v_o,
  output logic [counter_width_p-1:0]                   rd_data_o,
  input  logic                                         rd_yumi_i
);

  // Link layout: {fwd{v, packet, ready_and_rev}, rev{v, packet, ready_and_rev}}
  localparam int c_rev_width   = rev_pkt_width_lp + 2;
  localparam int c_rev_ready   = 0;
  localparam int c_rev_v       = c_rev_width - 1;
  localparam int c_fwd_ready   = c_rev_width;
  localparam int c_fwd_v       = link_sif_width_lp - 1;
  localparam int c_num_ctr     = 4*dirs_lp + 1;
  localparam int c_cycle_idx   = 4*dirs_lp;
  localparam logic [counter_width_p-1:0] c_one = counter_width_p'(1);

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_e;

  logic [c_num_ctr-1:0]       w_event;
  logic [c_num_ctr-1:0]       w_inc;
  logic [c_num_ctr-1:0]       w_ovf_next;
  logic [counter_width_p-1:0] w_next   [c_num_ctr];
  logic [counter_width_p-1:0] r_live   [c_num_ctr];
  logic [counter_width_p-1:0] r_shadow [c_num_ctr];
  logic [c_num_ctr-1:0]       r_ovf;
  logic [c_num_ctr-1:0]       r_shadow_ovf;
  logic [counter_width_p-1:0] w_rd_mux;
  logic [counter_width_p-1:0] r_rd_data;
  rd_state_e                  r_state;
  logic                       w_unused_links;

  for (genvar d = 0; d < dirs_lp; d++) begin : g_dir
    logic w_fwd_v, w_fwd_rdy, w_rev_v, w_rev_rdy;
    assign w_fwd_v   = links_sif_o[d][c_fwd_v];
    assign w_fwd_rdy = links_sif_i[d][c_fwd_ready];
    assign w_rev_v   = links_sif_o[d][c_rev_v];
    assign w_rev_rdy = links_sif_i[d][c_rev_ready];
    assign w_event[4*d+0] = w_fwd_v &  w_fwd_rdy;
    assign w_event[4*d+1] = w_fwd_v & ~w_fwd_rdy;
    assign w_event[4*d+2] = w_rev_v &  w_rev_rdy;
    assign w_event[4*d+3] = w_rev_v & ~w_rev_rdy;
  end

  assign w_event[c_cycle_idx] = 1'b1;
  assign w_inc                = w_event & {c_num_ctr{~freeze_i}};
  assign w_unused_links       = ^{links_sif_i, links_sif_o};

  // Saturating increment; an increment that would wrap sets the sticky bit instead
  always_comb begin
    for (int i = 0; i < c_num_ctr; i++) begin
      w_next[i]     = r_live[i];
      w_ovf_next[i] = r_ovf[i];
      if (w_inc[i]) begin
        if (&r_live[i]) w_ovf_next[i] = 1'b1;
        else            w_next[i]     = r_live[i] + c_one;
      end
    end
  end

  // Snapshot captures the post-increment value so the snapshot cycle closes its interval
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < c_num_ctr; i++) begin
        r_live[i]   <= '0;
        r_shadow[i] <= '0;
      end
      r_ovf        <= '0;
      r_shadow_ovf <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < c_num_ctr; i++) begin
        r_shadow[i] <= w_next[i];
        r_live[i]   <= '0;
      end
      r_shadow_ovf <= w_ovf_next;
      r_ovf        <= '0;
    end else begin
      for (int i = 0; i < c_num_ctr; i++) begin
        r_live[i] <= w_next[i];
      end
      r_ovf <= w_ovf_next;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (!rd_addr_i[4]) begin
      w_rd_mux = r_shadow[rd_addr_i[3:0]];
    end else if (rd_addr_i == 5'd16) begin
      w_rd_mux = r_shadow[c_cycle_idx];
    end else if (rd_addr_i == 5'd17) begin
      w_rd_mux[c_num_ctr-1:0] = r_shadow_ovf;
    end
  end

  // Data is latched at accept, so later snapshots never disturb an outstanding read
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= RD_IDLE;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (rd_v_i) begin
            r_rd_data <= w_rd_mux;
            r_state   <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (rd_yumi_i) r_state <= RD_IDLE;
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  assign rd_v_o     = (r_state == RD_BUSY);
  assign rd_ready_o = (r_state == RD_IDLE);
  assign rd_data_o  = r_rd_data;

endmodule
`default_nettype wire

// File: doc/bsg_manycore_link_profiler.md
# bsg_manycore_link_profiler

Synthesizable per-tile link traffic profiler that snoops the same four-direction link bundle a tile exposes (W, E, N, S) and counts outgoing forward/reverse transfers and stall cycles. It sits beside each tile's link ports, downstream of the link signals. It accumulates into live counters, copies them into a shadow bank on a snapshot pulse, and serves shadow values over a single-outstanding read handshake. This lets on-chip or host software read the same activity information that simulation traces print.

## Interface
- addr_width_p, "inv", packet address width (for link struct declaration)
- data_width_p, "inv", packet data width
- x_cord_width_p, "inv", X coordinate width
- y_cord_width_p, "inv", Y coordinate width
- load_id_width_p, "inv", load id width
- counter_width_p, 32, width of every counter and of rd_data_o (≥18)
- dirs_lp, 4, link directions, index order W=0, E=1, N=2, S=3
- link_sif_width_lp, derived, width of one bsg_manycore_link_sif_s

- clk_i  in  1  single clock; all state on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- links_sif_i  in  dirs_lp×link_sif_width_lp  tile's incoming link bundle (snoop only)
- links_sif_o  in  dirs_lp×link_sif_width_lp  tile's outgoing link bundle (snoop only)
- freeze_i  in  1  1 = counting suspended
- snapshot_i  in  1  pulse: copy live→shadow, clear live
- rd_v_i  in  1  read request valid
- rd_addr_i  in  5  shadow register index
- rd_ready_o  out  1  read request accepted when rd_v_i & rd_ready_o
- rd_v_o  out  1  read data valid
- rd_data_o  out  counter_width_p  read data
- rd_yumi_i  in  1  consumer takes rd_data_o; legal only when rd_v_o=1

## Operation
- Per direction d, events are sampled each cycle:
  - fwd_xfer = links_sif_o[d].fwd.v & links_sif_i[d].fwd.ready_and_rev
  - fwd_stall = links_sif_o[d].fwd.v & ~links_sif_i[d].fwd.ready_and_rev
  - rev_xfer and rev_stall are the same using .rev
- Live bank holds 18 entries:
  - 16 event counters, plus cycle counter (cycles with freeze_i=0), plus 17-bit sticky overflow vector.
- freeze_i=1: no live counter or overflow bit changes. Snapshot still honoured.
- Counters saturate at all-ones. An increment at all-ones keeps all-ones and sets that counter's overflow bit.
- Snapshot:
  - Shadow receives live value including the current cycle's increment (event in the snapshot cycle belongs to the closing interval).
  - Live counters and overflow bits become 0.
  - Back-to-back snapshots are legal. The second shadow reflects only the one intervening cycle.
- Shadow address map, addr = 4·d + k:
  - k: 0 fwd_xfer, 1 fwd_stall, 2 rev_xfer, 3 rev_stall.
  - 16 = cycle count.
  - 17 = overflow vector, zero-extended: bit 4·d+k for event counters, bit 16 for cycle counter.
  - 18–31 read as 0.
- Read FSM, two states:
  - IDLE (rd_v_o=0, rd_ready_o=1): on rd_v_i, register shadow[rd_addr_i] into rd_data_o and go to BUSY.
  - BUSY (rd_v_o=1): on rd_yumi_i, go to IDLE. rd_data_o is stable while BUSY.
  - rd_ready_o = ~rd_v_o. No bypass; at most one read per 2 cycles.
- A snapshot while BUSY does not alter rd_data_o; the value was captured at accept.
- A read accepted in the same cycle as snapshot_i returns the pre-snapshot shadow value.

## Timing
- Reset (async assert, sync-safe deassert): all live and shadow counters 0; overflow 0; FSM IDLE; rd_v_o=0; rd_ready_o=1; rd_data_o=0.
- Event to live-counter visibility is 1 cycle. Visibility through a read needs snapshot then read.
- Read latency: accept at cycle t, rd_v_o=1 and data valid at t+1.
- Reset asserted while BUSY: immediately IDLE, outstanding read dropped.
- Snapshoting and incrementing share one adder per counter. No multi-cycle paths.

## Test plan
- Reset:
  - Stimulus: assert reset_n_i=0 mid-read (BUSY), then release.
  - Required response: rd_v_o=0 and rd_ready_o=1 asynchronously. Reading addr 0 after a snapshot returns 0.
- Transfer/stall counting:
  - Stimulus: W fwd.v=1 for 10 cycles, ready=1 on cycles 0–5 and 0 on cycles 6–9. Snapshot, then read addr 0 and addr 1.
  - Required response: addr 0 returns 6, addr 1 returns 4, addr 16 returns cycles elapsed since reset.
- Freeze:
  - Stimulus: S rev transfers on 8 cycles, freeze_i=1 during 3 of them, then snapshot.
  - Required response: addr 14 returns 5. Cycle count excludes frozen cycles.
- Saturation:
  - Stimulus: counter_width_p=18. Force 2^18+3 E fwd transfers, then snapshot.
  - Required response: addr 4 returns 0x3FFFF. Addr 17 has bit 4 set. After a second snapshot, addr 17 returns 0.
- Snapshot boundary:
  - Stimulus: N fwd transfer in the same cycle as snapshot_i, plus one transfer the next cycle. Snapshot again.
  - Required response: first shadow addr 8 = prior+1. Second shadow addr 8 = 1.
- Read handshake:
  - Stimulus: hold rd_v_i=1 continuously and delay rd_yumi_i by 3 cycles. Pulse snapshot while BUSY.
  - Required response: rd_ready_o=0 during BUSY. rd_data_o unchanged until yumi. Addresses 18–31 return 0.
